ysyx_22040237_core_ctrl: RTL

//  Multi-cycle sequencer for the NPC datapath: owns the PC, fetches over a valid/ready

---
 rtl/ysyx_22040237_core_ctrl_if.sv | 25 ++
 rtl/ysyx_22040237_core_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_core_ctrl_if.sv
// Instruction-fetch handshake between the core sequencer and instruction memory.
// The master drives a valid/ready request; the slave returns a response-valid and the instruction.
interface ysyx_22040237_core_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_inst;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_inst
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_inst
    );
endinterface

// File: rtl/ysyx_22040237_core_ctrl.sv
// Multi-cycle NPC sequencer: owns the PC, fetches, gates execute/writeback, halts on ebreak/fault.
// Define YSYX_22040237_PERF_CNT_EN to build the 64-bit cycle and retired-instruction counters.
module ysyx_22040237_core_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned FETCH_TMO = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ysyx_22040237_core_ctrl_if.master        ifu,
    output logic [31:0]                      pc,
    output logic [31:0]                      inst_q,
    input  logic                             dec_ebreak,
    input  logic                             dec_rd_w_en,
    output logic                             exu_valid,
    input  logic                             exu_done,
    input  logic                             exu_npc_vld,
    input  logic [31:0]                      exu_npc,
    output logic                             wb_en,
    output logic                             halt,
    output logic                             halt_err,
    output logic [63:0]                      cycle_cnt,
    output logic [63:0]                      inst_cnt
);

    localparam int unsigned TmoW = $clog2(FETCH_TMO + 1);
    // Counter value seen in the last FETCH_WAIT cycle before the fault halt.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(FETCH_TMO - 2);

    typedef enum logic [2:0] {
        StIdle,
        StFetchReq,
        StFetchWait,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_lat_q, inst_lat_d;
    logic              npc_vld_q, npc_vld_d;
    logic [31:0]       npc_q, npc_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              exec_first_q, exec_first_d;
    logic              halt_err_q, halt_err_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_lat_d   = inst_lat_q;
        npc_vld_d    = npc_vld_q;
        npc_d        = npc_q;
        tmo_d        = tmo_q;
        exec_first_d = 1'b0;
        halt_err_d   = halt_err_q;
        unique case (state_q)
            StIdle: state_d = StFetchReq;
            StFetchReq: begin
                if (ifu.req_ready) begin
                    state_d = StFetchWait;
                    tmo_d   = '0;
                end
            end
            StFetchWait: begin
                // A response arriving in the timeout cycle still wins.
                if (ifu.rsp_valid) begin
                    inst_lat_d   = ifu.rsp_inst;
                    tmo_d        = '0;
                    exec_first_d = 1'b1;
                    state_d      = StExec;
                end else if (tmo_q == TmoLast) begin
                    tmo_d      = '0;
                    halt_err_d = 1'b1;
                    state_d    = StHalt;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StExec: begin
                if (exec_first_q && dec_ebreak) begin
                    halt_err_d = 1'b0;
                    state_d    = StHalt;
                end else if (exu_done) begin
                    if (exu_npc_vld && (exu_npc[1:0] != 2'b00)) begin
                        halt_err_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        npc_vld_d = exu_npc_vld;
                        npc_d     = exu_npc;
                        state_d   = StWb;
                    end
                end
            end
            StWb: begin
                pc_d    = npc_vld_q ? npc_q : pc_q + 32'd4;
                state_d = StFetchReq;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            inst_lat_q   <= 32'h0;
            npc_vld_q    <= 1'b0;
            npc_q        <= 32'h0;
            tmo_q        <= '0;
            exec_first_q <= 1'b0;
            halt_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_lat_q   <= inst_lat_d;
            npc_vld_q    <= npc_vld_d;
            npc_q        <= npc_d;
            tmo_q        <= tmo_d;
            exec_first_q <= exec_first_d;
            halt_err_q   <= halt_err_d;
        end
    end

    always_comb begin
        ifu.req_valid = (state_q == StFetchReq);
        exu_valid     = (state_q == StExec);
        wb_en         = (state_q == StWb) && dec_rd_w_en;
        halt          = (state_q == StHalt);
    end

    assign ifu.req_addr = pc_q;
    assign pc           = pc_q;
    assign inst_q       = inst_lat_q;
    assign halt_err     = halt_err_q;

`ifdef YSYX_22040237_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] inst_cnt_q, inst_cnt_d;
    logic        retire;

    always_comb begin
        // An ebreak retires on its way into HALT; everything else retires in WB.
        retire      = (state_q == StWb) ||
                      ((state_q == StExec) && exec_first_q && dec_ebreak);
        cycle_cnt_d = (state_q != StHalt) ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
        inst_cnt_d  = retire ? inst_cnt_q + 64'd1 : inst_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= 64'h0;
            inst_cnt_q  <= 64'h0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
`else
    assign cycle_cnt = 64'h0;
    assign inst_cnt  = 64'h0;
`endif

endmodule
